// File: rtl/switch_debouncer_pkg.sv
// Shared types and defaults for the switch debouncer.
//   state_e                 : 2-bit debounce FSM state encoding
//   DEBOUNCE_CYCLES_DEFAULT : samples needed to accept a new level (10 ms at 100 MHz)
//   SYNC_STAGES_DEFAULT     : synchroniser depth
package switch_debouncer_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;
  localparam int unsigned SYNC_STAGES_DEFAULT     = 2;

endpackage

// File: rtl/bit_synchronizer.sv
// N-stage flop chain bringing one asynchronous bit into the clk domain.
// Ports:
//   clk : destination clock
//   rst : asynchronous, active-high reset (chain clears to 0)
//   d   : asynchronous input bit
//   q   : synchronised output (last stage of the chain)
module bit_synchronizer #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/switch_debouncer.sv
// Debounces a mechanical switch/button into a clean level plus one-cycle edge pulses.
// Optional feature macro: SWITCH_DEBOUNCER_TOGGLE_EN adds a toggle output that
// flips on every accepted rising edge (push-button start/stop).
// Ports:
//   clk    : system clock
//   rst    : asynchronous, active-high reset
//   sw_in  : raw switch pin, asynchronous to clk
//   level  : debounced level
//   rise   : one-cycle pulse when level goes 0->1
//   fall   : one-cycle pulse when level goes 1->0
//   toggle : (SWITCH_DEBOUNCER_TOGGLE_EN only) flips with each rise
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_in,
  output logic level,
  output logic rise,
  output logic fall
`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
  ,
  output logic toggle
`endif
);

  localparam int unsigned    CntW    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic            sw_sync;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sw_in),
    .q   (sw_sync)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // The first mismatching sample, seen in a STABLE state, already counts as
  // sample one, so the WAIT state starts at 1 and accepts on the last sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      STABLE_LO: begin
        cnt_d = '0;
        if (sw_sync) begin
          state_d = WAIT_HI;
          cnt_d   = CntOne;
        end
      end
      WAIT_HI: begin
        if (!sw_sync) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      STABLE_HI: begin
        cnt_d = '0;
        if (!sw_sync) begin
          state_d = WAIT_LO;
          cnt_d   = CntOne;
        end
      end
      WAIT_LO: begin
        if (sw_sync) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
    endcase
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
  logic toggle_q;

  // Flips on the same edge that raises rise, so toggle changes with the pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toggle_q <= 1'b0;
    end else begin
      toggle_q <= toggle_q ^ rise_d;
    end
  end

  assign toggle = toggle_q;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer (DEBOUNCE_CYCLES=16, SYNC_STAGES=2).
module tb_switch_debouncer;

  localparam int unsigned DC = 16;
  localparam int unsigned SS = 2;
  localparam int unsigned LAT = DC + SS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sw_in = 1'b0;
  logic level, rise, fall;
`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
  logic toggle;
`endif

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;

  switch_debouncer #(
    .DEBOUNCE_CYCLES (DC),
    .SYNC_STAGES     (SS)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sw_in  (sw_in),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
    ,
    .toggle (toggle)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: wait for the rising edge, then sample just after it.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic v);
    @(negedge clk);
    sw_in = v;
  endtask

  // Reference model: the level flips once the DC most recent synchronised
  // samples all disagree with it. Synchronised samples are the raw pin values
  // delayed by SS clocks, so the window excludes the SS newest entries.
  bit   hist[$];
  logic exp_level = 1'b0;
  logic exp_rise = 1'b0;
  logic exp_fall = 1'b0;
  logic exp_toggle = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      hist.delete();
      exp_level = 1'b0;
      exp_rise = 1'b0;
      exp_fall = 1'b0;
      exp_toggle = 1'b0;
    end else begin
      bit all_diff;
      hist.push_back(sw_in);
      if (hist.size() > LAT) void'(hist.pop_front());
      exp_rise = 1'b0;
      exp_fall = 1'b0;
      if (hist.size() == LAT) begin
        all_diff = 1'b1;
        for (int i = 0; i < int'(DC); i++) if (hist[i] == exp_level) all_diff = 1'b0;
        if (all_diff) begin
          exp_level = ~exp_level;
          exp_rise = exp_level;
          exp_fall = ~exp_level;
          exp_toggle = exp_toggle ^ exp_rise;
        end
      end
    end
    #1;
    if (mon_en && !rst) begin
      check("model_level", level, exp_level);
      check("model_rise", rise, exp_rise);
      check("model_fall", fall, exp_fall);
`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
      check("model_toggle", toggle, exp_toggle);
`endif
    end
  end

  typedef struct {
    logic sw;
    int   cycles;
    logic exp_level;
    int   exp_rises;
    int   exp_falls;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int rises, falls;

    vecs[0]  = '{1'b1, 40, 1'b1, 1, 0};  // clean press
    vecs[1]  = '{1'b0, 15, 1'b1, 0, 0};  // short low glitch...
    vecs[2]  = '{1'b1, 10, 1'b1, 0, 0};  // ...rejected
    vecs[3]  = '{1'b0, 40, 1'b0, 0, 1};  // clean release
    vecs[4]  = '{1'b1, 15, 1'b0, 0, 0};  // 15-cycle high glitch...
    vecs[5]  = '{1'b0, 20, 1'b0, 0, 0};  // ...rejected
    vecs[6]  = '{1'b1, 16, 1'b0, 0, 0};  // exactly DC wide: accepted later
    vecs[7]  = '{1'b0, 40, 1'b0, 1, 1};  // rise lands here, then fall
    vecs[8]  = '{1'b1, 17, 1'b0, 0, 0};
    vecs[9]  = '{1'b1, 25, 1'b1, 1, 0};
    vecs[10] = '{1'b0, 30, 1'b0, 0, 1};

    // Reset state
    tick(3);
    check("reset_level", level, 1'b0);
    check("reset_rise", rise, 1'b0);
    check("reset_fall", fall, 1'b0);
`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
    check("reset_toggle", toggle, 1'b0);
`endif
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    tick(20);

    // Table-driven segments
    foreach (vecs[k]) begin
      drive(vecs[k].sw);
      rises = 0;
      falls = 0;
      repeat (vecs[k].cycles) begin
        tick(1);
        rises += int'(rise);
        falls += int'(fall);
      end
      check($sformatf("vec%0d_level", k), level, vecs[k].exp_level);
      check($sformatf("vec%0d_rises", k), rises, vecs[k].exp_rises);
      check($sformatf("vec%0d_falls", k), falls, vecs[k].exp_falls);
    end

    // Clean press: latency of exactly SS+DC edges
    drive(1'b1);
    tick(LAT - 1);
    check("press_before_level", level, 1'b0);
    check("press_before_rise", rise, 1'b0);
    tick(1);
    check("press_level", level, 1'b1);
    check("press_rise", rise, 1'b1);
    check("press_fall", fall, 1'b0);
    tick(1);
    check("press_rise_one_cycle", rise, 1'b0);
    tick(20);

    // Clean release
    drive(1'b0);
    tick(LAT - 1);
    check("release_before_level", level, 1'b1);
    check("release_before_fall", fall, 1'b0);
    tick(1);
    check("release_level", level, 1'b0);
    check("release_fall", fall, 1'b1);
    check("release_rise", rise, 1'b0);
    tick(1);
    check("release_fall_one_cycle", fall, 1'b0);
    tick(10);

    // Bounce every 3 cycles for 30 cycles, then settle high
    for (int i = 0; i < 10; i++) begin
      drive(~i[0]);
      repeat (3) begin
        tick(1);
        check("bounce_quiet", {level, rise, fall}, 3'b000);
      end
    end
    drive(1'b1);
    tick(LAT - 1);
    check("bounce_before_level", level, 1'b0);
    tick(1);
    check("bounce_rise", rise, 1'b1);
    check("bounce_level", level, 1'b1);
    tick(10);

    // Async reset while level is high clears outputs before the next edge
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst_level", level, 1'b0);
    tick(2);
    @(negedge clk);
    sw_in = 1'b0;
    rst = 1'b0;
    tick(25);

    // Reset 8 cycles into a WAIT_HI count, release with sw_in held high
    drive(1'b1);
    tick(SS + 8);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midwait_rst_out", {level, rise, fall}, 3'b000);
    repeat (4) begin
      tick(1);
      check("midwait_in_rst", {level, rise, fall}, 3'b000);
    end
    @(negedge clk);
    rst = 1'b0;
    tick(LAT - 1);
    check("midwait_before_level", level, 1'b0);
    check("midwait_before_rise", rise, 1'b0);
    tick(1);
    check("midwait_rise", rise, 1'b1);
    check("midwait_level", level, 1'b1);
    tick(10);
    drive(1'b0);
    tick(30);

`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
    // Three press/release cycles: toggle reads 1, 0, 1, changing with rise only
    @(negedge clk);
    rst = 1'b1;
    tick(2);
    @(negedge clk);
    rst = 1'b0;
    tick(20);
    for (int p = 0; p < 3; p++) begin
      logic want;
      want = (p % 2 == 0);
      drive(1'b1);
      tick(LAT - 1);
      check("toggle_before_rise", toggle, ~want);
      tick(1);
      check("toggle_on_rise", toggle, want);
      check("toggle_rise", rise, 1'b1);
      tick(20);
      drive(1'b0);
      tick(LAT);
      check("toggle_fall", fall, 1'b1);
      check("toggle_after_fall", toggle, want);
      tick(15);
    end
`endif

    // Random segments checked against the reference model
    for (int s = 0; s < 60; s++) begin
      drive(1'($urandom_range(0, 1)));
      tick(int'($urandom_range(1, 40)));
    end
    drive(1'b0);
    tick(LAT + 5);
    check("final_level", level, 1'b0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
